reg_write_scoreboard: RTL and testbench

- Producer-side companion to the decode-stage forwarding selector.
- Tracks in-flight GPR writes issued from decode: per-register countdown until the value can be forwarded back to D.
- Raises stall_d when a decode-stage source is not yet forwardable.
- Sits beside the D/E pipeline register; issue comes from D, flush from the exception/branch-kill logic.

---
 rtl/reg_write_scoreboard.sv | 114 +++++++++++
 tb/tb_reg_write_scoreboard.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_scoreboard.sv
// rtl/reg_write_scoreboard.sv - in-flight GPR write scoreboard raising the decode-stage stall
// Optional stall counter output stall_cycles is built only when SCOREBOARD_STATS_EN is defined.
module reg_write_scoreboard #(
    parameter int ALU_LAT  = 0,
    parameter int LOAD_LAT = 2,
    parameter int MUL_LAT  = 3,
    parameter int CNT_W    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_fire,
    input  logic        issue_wen,
    input  logic [4:0]  issue_dst,
    input  logic [1:0]  issue_cls,
    input  logic        flush_e,
    input  logic [4:0]  src_a,
    input  logic [4:0]  src_b,
    input  logic        src_a_used,
    input  logic        src_b_used,
    input  logic        need_in_d,
    output logic        stall_d,
`ifdef SCOREBOARD_STATS_EN
    output logic [31:0] stall_cycles,
`endif
    output logic [31:0] busy
);

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAT_ALU  = CNT_W'(ALU_LAT);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] LAT_MUL  = CNT_W'(MUL_LAT);

    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];
    logic             last_valid_q, last_valid_d;
    logic [4:0]       last_dst_q, last_dst_d;
    logic [CNT_W-1:0] last_prev_q, last_prev_d;

    logic [CNT_W-1:0] slack;
    logic [CNT_W-1:0] issue_lat;
    logic             stall_a, stall_b;
    logic             issue_acc;

    // A consumer resolving in E gets one extra cycle of slack through E-stage forwarding.
    assign slack   = need_in_d ? '0 : ONE;
    assign stall_a = src_a_used && (src_a != 5'd0) && (cnt_q[src_a] > slack);
    assign stall_b = src_b_used && (src_b != 5'd0) && (cnt_q[src_b] > slack);
    assign stall_d = stall_a | stall_b;

    assign issue_acc = issue_fire && issue_wen && (issue_dst != 5'd0) && !stall_d;

    always_comb begin
        case (issue_cls)
            2'd1:    issue_lat = LAT_LOAD;
            2'd2:    issue_lat = LAT_MUL;
            default: issue_lat = LAT_ALU;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - ONE : '0;
        end
        // A killed instruction hands its register back to the older writer, aged by this edge.
        if (flush_e && last_valid_q) begin
            cnt_d[last_dst_q] = (last_prev_q != '0) ? last_prev_q - ONE : '0;
        end
        if (issue_acc) begin
            cnt_d[issue_dst] = issue_lat;
        end
        last_valid_d = issue_acc;
        last_dst_d   = issue_acc ? issue_dst : last_dst_q;
        last_prev_d  = issue_acc ? cnt_q[issue_dst] : last_prev_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= '0;
            end
            last_valid_q <= 1'b0;
            last_dst_q   <= 5'd0;
            last_prev_q  <= '0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            last_valid_q <= last_valid_d;
            last_dst_q   <= last_dst_d;
            last_prev_q  <= last_prev_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            busy[i] = (cnt_q[i] != '0);
        end
    end

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= 32'd0;
        end else if (stall_d && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// tb/tb_reg_write_scoreboard.sv - directed and randomized checks of reg_write_scoreboard
module tb_reg_write_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_fire, issue_wen, flush_e;
    logic [4:0]  issue_dst, src_a, src_b;
    logic [1:0]  issue_cls;
    logic        src_a_used, src_b_used, need_in_d;
    logic        stall_d;
    logic [31:0] busy;
`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    int m_cnt [32];
    bit m_lv;
    int m_ld, m_lp;
    int m_stats;

    reg_write_scoreboard dut (
        .clk(clk), .reset(reset),
        .issue_fire(issue_fire), .issue_wen(issue_wen),
        .issue_dst(issue_dst), .issue_cls(issue_cls),
        .flush_e(flush_e),
        .src_a(src_a), .src_b(src_b),
        .src_a_used(src_a_used), .src_b_used(src_b_used),
        .need_in_d(need_in_d),
        .stall_d(stall_d),
`ifdef SCOREBOARD_STATS_EN
        .stall_cycles(stall_cycles),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int lat_of(input logic [1:0] c);
        if (c == 2'd1) return 2;
        if (c == 2'd2) return 3;
        return 0;
    endfunction

    function automatic bit exp_stall();
        int slack = need_in_d ? 0 : 1;
        bit a = src_a_used && (src_a != 0) && (m_cnt[src_a] > slack);
        bit b = src_b_used && (src_b != 0) && (m_cnt[src_b] > slack);
        return a || b;
    endfunction

    function automatic logic [31:0] exp_busy();
        logic [31:0] r = '0;
        for (int i = 0; i < 32; i++) r[i] = (m_cnt[i] > 0);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_lv = 0; m_ld = 0; m_lp = 0; m_stats = 0;
    endtask

    task automatic tick();
        int  nxt [32];
        bit  st  = exp_stall();
        bit  acc = issue_fire && issue_wen && (issue_dst != 0) && !st;
        for (int i = 0; i < 32; i++) nxt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        if (flush_e && m_lv) nxt[m_ld] = (m_lp > 0) ? m_lp - 1 : 0;
        if (acc) begin
            nxt[issue_dst] = lat_of(issue_cls);
            m_lp = m_cnt[issue_dst];
            m_ld = issue_dst;
        end
        m_lv = acc;
        if (st) m_stats++;
        for (int i = 0; i < 32; i++) m_cnt[i] = nxt[i];
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        issue_fire = 0; issue_wen = 0; issue_dst = 0; issue_cls = 0;
        flush_e = 0; src_a = 0; src_b = 0; src_a_used = 0; src_b_used = 0; need_in_d = 0;
    endtask

    task automatic do_issue(input logic [4:0] dst, input logic [1:0] cls);
        drive_idle();
        issue_fire = 1; issue_wen = 1; issue_dst = dst; issue_cls = cls;
    endtask

    task automatic test_reset();
        reset = 1;
        drive_idle();
        model_reset();
        #1;
        n_checks++; if (stall_d !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall_d); else n_pass++;
        n_checks++; if (busy !== 32'd0) $display("FAIL reset_busy got=%h exp=0", busy); else n_pass++;
`ifdef SCOREBOARD_STATS_EN
        n_checks++; if (stall_cycles !== 32'd0) $display("FAIL reset_stats got=%0d exp=0", stall_cycles); else n_pass++;
`endif
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic test_load_use();
        do_issue(5'd5, 2'd1);
        tick();
        drive_idle(); src_a = 5; src_a_used = 1; need_in_d = 0;
        #1;
        n_checks++; if (stall_d !== 1'b1) $display("FAIL load_use_stall0 got=%b exp=1", stall_d); else n_pass++;
        n_checks++; if (busy[5] !== 1'b1) $display("FAIL load_use_busy0 got=%b exp=1", busy[5]); else n_pass++;
        tick();
        n_checks++; if (stall_d !== 1'b0) $display("FAIL load_use_stall1 got=%b exp=0", stall_d); else n_pass++;
        n_checks++; if (busy[5] !== 1'b1) $display("FAIL load_use_busy1 got=%b exp=1", busy[5]); else n_pass++;
        tick();
        n_checks++; if (busy[5] !== 1'b0) $display("FAIL load_use_busy2 got=%b exp=0", busy[5]); else n_pass++;
    endtask

    task automatic test_branch();
        do_issue(5'd5, 2'd1);
        tick();
        drive_idle(); src_a = 5; src_a_used = 1; need_in_d = 1;
        #1;
        n_checks++; if (stall_d !== 1'b1) $display("FAIL branch_stall0 got=%b exp=1", stall_d); else n_pass++;
        tick();
        n_checks++; if (stall_d !== 1'b1) $display("FAIL branch_stall1 got=%b exp=1", stall_d); else n_pass++;
        tick();
        n_checks++; if (stall_d !== 1'b0) $display("FAIL branch_stall2 got=%b exp=0", stall_d); else n_pass++;
        do_issue(5'd5, 2'd0);
        tick();
        drive_idle(); src_a = 5; src_a_used = 1; need_in_d = 1;
        #1;
        n_checks++; if (stall_d !== 1'b0) $display("FAIL branch_alu_stall got=%b exp=0", stall_d); else n_pass++;
        n_checks++; if (busy[5] !== 1'b0) $display("FAIL branch_alu_busy got=%b exp=0", busy[5]); else n_pass++;
        tick();
    endtask

    task automatic test_flush();
        do_issue(5'd8, 2'd2);
        tick();
        drive_idle(); flush_e = 1;
        #1;
        n_checks++; if (busy[8] !== 1'b1) $display("FAIL flush_busy_pre got=%b exp=1", busy[8]); else n_pass++;
        tick();
        drive_idle(); src_a = 8; src_a_used = 1; need_in_d = 1;
        #1;
        n_checks++; if (busy[8] !== 1'b0) $display("FAIL flush_busy_post got=%b exp=0", busy[8]); else n_pass++;
        n_checks++; if (stall_d !== 1'b0) $display("FAIL flush_stall got=%b exp=0", stall_d); else n_pass++;
        tick();
    endtask

    task automatic test_waw();
        do_issue(5'd3, 2'd1);
        tick();
        do_issue(5'd3, 2'd0);
        #1;
        n_checks++; if (stall_d !== 1'b0) $display("FAIL waw_issue_stall got=%b exp=0", stall_d); else n_pass++;
        tick();
        drive_idle(); src_b = 3; src_b_used = 1; need_in_d = 1;
        #1;
        n_checks++; if (stall_d !== 1'b0) $display("FAIL waw_stall got=%b exp=0", stall_d); else n_pass++;
        n_checks++; if (busy[3] !== 1'b0) $display("FAIL waw_busy got=%b exp=0", busy[3]); else n_pass++;
        tick();
    endtask

    task automatic test_r0();
        do_issue(5'd0, 2'd2);
        src_a = 0; src_a_used = 1; src_b = 0; src_b_used = 1; need_in_d = 1;
        #1;
        n_checks++; if (stall_d !== 1'b0) $display("FAIL r0_stall0 got=%b exp=0", stall_d); else n_pass++;
        n_checks++; if (busy !== 32'd0) $display("FAIL r0_busy0 got=%h exp=0", busy); else n_pass++;
        tick();
        issue_fire = 0;
        #1;
        n_checks++; if (stall_d !== 1'b0) $display("FAIL r0_stall1 got=%b exp=0", stall_d); else n_pass++;
        n_checks++; if (busy !== 32'd0) $display("FAIL r0_busy1 got=%h exp=0", busy); else n_pass++;
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            issue_fire = 1'($urandom_range(0, 1));
            issue_wen  = 1'($urandom_range(0, 3) != 0);
            issue_dst  = 5'($urandom_range(0, 7));
            issue_cls  = 2'($urandom_range(0, 3));
            flush_e    = 1'($urandom_range(0, 5) == 0);
            src_a      = 5'($urandom_range(0, 7));
            src_b      = 5'($urandom_range(0, 7));
            src_a_used = 1'($urandom_range(0, 1));
            src_b_used = 1'($urandom_range(0, 1));
            need_in_d  = 1'($urandom_range(0, 1));
            if (exp_stall()) issue_fire = 0;
            #1;
            n_checks++;
            if (stall_d !== exp_stall()) $display("FAIL rand_stall cyc=%0d got=%b exp=%b", n, stall_d, exp_stall());
            else n_pass++;
            n_checks++;
            if (busy !== exp_busy()) $display("FAIL rand_busy cyc=%0d got=%h exp=%h", n, busy, exp_busy());
            else n_pass++;
            tick();
        end
`ifdef SCOREBOARD_STATS_EN
        n_checks++;
        if (stall_cycles !== 32'(m_stats)) $display("FAIL rand_stats got=%0d exp=%0d", stall_cycles, m_stats);
        else n_pass++;
`endif
        drive_idle();
        repeat (4) tick();
    endtask

    task automatic test_reset_mid_stall();
        do_issue(5'd9, 2'd2);
        tick();
        drive_idle(); src_a = 9; src_a_used = 1; need_in_d = 0;
        #1;
        n_checks++; if (stall_d !== 1'b1) $display("FAIL rst_mid_pre got=%b exp=1", stall_d); else n_pass++;
        reset = 1;
        #1;
        n_checks++; if (stall_d !== 1'b0) $display("FAIL rst_mid_stall got=%b exp=0", stall_d); else n_pass++;
        n_checks++; if (busy !== 32'd0) $display("FAIL rst_mid_busy got=%h exp=0", busy); else n_pass++;
`ifdef SCOREBOARD_STATS_EN
        n_checks++; if (stall_cycles !== 32'd0) $display("FAIL rst_mid_stats got=%0d exp=0", stall_cycles); else n_pass++;
`endif
        model_reset();
        reset = 0;
        do_issue(5'd9, 2'd2);
        tick();
        drive_idle(); src_a = 9; src_a_used = 1; need_in_d = 0;
        repeat (3) tick();
`ifdef SCOREBOARD_STATS_EN
        n_checks++; if (stall_cycles !== 32'd2) $display("FAIL mul_stats got=%0d exp=2", stall_cycles); else n_pass++;
`endif
        n_checks++; if (stall_d !== 1'b0) $display("FAIL mul_stall_end got=%b exp=0", stall_d); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_flush();
        test_waw();
        test_r0();
        test_random();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
